res_buf: RTL and testbench

Sequential result buffer that sits directly downstream of the IP-catalog operator units (squarer, bitwise AND, concatenator), all of which produce a 5-bit result. Captures each result with a 2-bit operator tag into a small FIFO, presents results to the consumer over a valid/ready handshake, and optionally keeps a saturating running sum of every result delivered.

---
 rtl/res_pkg.sv | 18 +
 rtl/res_fifo_mem.sv | 32 +++
 rtl/res_buf.sv | 127 ++++++++++++
 tb/tb_res_buf.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/res_pkg.sv
// Shared types for the result buffer: operator tags and the stored entry layout.
package res_pkg;

  localparam int RES_W = 5;

  typedef enum logic [1:0] {
    OP_SQR = 2'b00,
    OP_AND = 2'b01,
    OP_CAT = 2'b10,
    OP_RSV = 2'b11
  } op_t;

  typedef struct packed {
    op_t              op;
    logic [RES_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/res_fifo_mem.sv
// Register-array storage for the result buffer: one write port, asynchronous read port.
module res_fifo_mem
  import res_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = RES_W + 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]             wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [W-1:0]             rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  // Storage is cleared on reset so the head reads as zero until the first push lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/res_buf.sv
// Result buffer FIFO with valid/ready handshake on both sides.
// Defining RES_ACC_EN adds a saturating running sum of every delivered result.
module res_buf
  import res_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = RES_W,
  parameter int ACC_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       ina,
  input  logic [1:0]             in_op,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       outa,
  output logic [1:0]             out_op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count
`ifdef RES_ACC_EN
  ,
  input  logic                   acc_clr,
  output logic [ACC_W-1:0]       acc,
  output logic                   acc_sat
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full, empty, push, pop;
  logic [WIDTH+1:0] rd_word;
  op_t              head_op;

  // Handshake flags come from registered occupancy only.
  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && !full;
  assign pop       = out_ready && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  res_fifo_mem #(
    .DEPTH (DEPTH),
    .W     (WIDTH + 2)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i ({in_op, ina}),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_word)
  );

  assign head_op = op_t'(rd_word[WIDTH+1:WIDTH]);
  assign outa    = rd_word[WIDTH-1:0];
  assign out_op  = head_op;
  assign count   = count_q;

`ifdef RES_ACC_EN
  localparam int SW = ACC_W + 1;
  localparam logic [SW-1:0] ACC_MAX = {1'b0, {ACC_W{1'b1}}};

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             sat_q, sat_d;
  logic [SW-1:0]    sum;

  // Clear wins over a same-cycle pop; the sum is one bit wider so overflow is visible.
  always_comb begin
    sum   = {1'b0, acc_q} + SW'(outa);
    acc_d = acc_q;
    sat_d = sat_q;
    if (acc_clr) begin
      acc_d = '0;
      sat_d = 1'b0;
    end else if (pop) begin
      if (sum > ACC_MAX) begin
        acc_d = '1;
        sat_d = 1'b1;
      end else begin
        acc_d = sum[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      sat_q <= sat_d;
    end
  end

  assign acc     = acc_q;
  assign acc_sat = sat_q;
`endif

endmodule

// File: tb/tb_res_buf.sv
// Self-checking bench for res_buf: queue-based reference model plus directed literal checks.
module tb_res_buf;
  import res_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] ina;
  logic [1:0] in_op;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] outa;
  logic [1:0] out_op;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] count;
  logic       acc_clr;
`ifdef RES_ACC_EN
  logic [7:0] acc;
  logic       acc_sat;
`endif

  int testsRun = 0;
  int testsFailed = 0;

  entry_t mq[$];
`ifdef RES_ACC_EN
  int macc = 0;
  bit msat = 1'b0;
`endif

  res_buf #(.DEPTH(DEPTH), .WIDTH(5), .ACC_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ina       (ina),
    .in_op     (in_op),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .outa      (outa),
    .out_op    (out_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
`ifdef RES_ACC_EN
    ,
    .acc_clr   (acc_clr),
    .acc       (acc),
    .acc_sat   (acc_sat)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, let the next rising edge consume them, return 2ns later.
  task automatic applyStimulus(input logic iv, input logic [1:0] op, input logic [4:0] d,
                               input logic ordy, input logic clr);
    in_valid  = iv;
    in_op     = op;
    ina       = d;
    out_ready = ordy;
    acc_clr   = clr;
    @(posedge clk);
    #2;
  endtask

  // Reference model: a FIFO queue of entries plus a clamped integer sum.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
`ifdef RES_ACC_EN
      macc = 0;
      msat = 1'b0;
`endif
    end else begin
      bit     doPop;
      bit     doPush;
      entry_t e;
      doPop  = out_ready && (mq.size() > 0);
      doPush = in_valid && (mq.size() < DEPTH);
`ifdef RES_ACC_EN
      if (acc_clr) begin
        macc = 0;
        msat = 1'b0;
      end else if (doPop) begin
        macc = macc + int'(mq[0].data);
        if (macc > 255) begin
          macc = 255;
          msat = 1'b1;
        end
      end
`endif
      if (doPop) void'(mq.pop_front());
      if (doPush) begin
        e.op   = op_t'(in_op);
        e.data = ina;
        mq.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("m_count", 32'(count), 32'(mq.size()));
    checkOutput("m_out_valid", 32'(out_valid), 32'(mq.size() != 0));
    checkOutput("m_in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
    if (mq.size() > 0) begin
      checkOutput("m_outa", 32'(outa), 32'(mq[0].data));
      checkOutput("m_out_op", 32'(out_op), 32'(mq[0].op));
    end
`ifdef RES_ACC_EN
    checkOutput("m_acc", 32'(acc), 32'(macc));
    checkOutput("m_acc_sat", 32'(acc_sat), 32'(msat));
`endif
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int drainA[4];
    int drainB[4];
    drainA = '{1, 2, 3, 4};
    drainB = '{11, 12, 13, 20};

    in_valid = 0; in_op = 0; ina = 0; out_ready = 0; acc_clr = 0;
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    checkOutput("rst_count", 32'(count), 0);
    checkOutput("rst_out_valid", 32'(out_valid), 0);
    checkOutput("rst_in_ready", 32'(in_ready), 1);
    checkOutput("rst_outa", 32'(outa), 0);
    checkOutput("rst_out_op", 32'(out_op), 0);
`ifdef RES_ACC_EN
    checkOutput("rst_acc", 32'(acc), 0);
    checkOutput("rst_acc_sat", 32'(acc_sat), 0);
`endif
    rst_n = 1'b1;
    applyStimulus(0, 2'b00, 5'd0, 0, 0);

    // Single push becomes visible one cycle later
    applyStimulus(1, 2'b00, 5'd9, 0, 0);
    checkOutput("push1_out_valid", 32'(out_valid), 1);
    checkOutput("push1_outa", 32'(outa), 9);
    checkOutput("push1_out_op", 32'(out_op), 0);
    checkOutput("push1_count", 32'(count), 1);
    applyStimulus(0, 2'b00, 5'd0, 1, 0);
    checkOutput("pop1_count", 32'(count), 0);

    // Fill to full, extra push ignored, drain in order
    for (int i = 1; i <= 4; i++) applyStimulus(1, 2'(i - 1), 5'(i), 0, 0);
    checkOutput("full_count", 32'(count), 4);
    checkOutput("full_in_ready", 32'(in_ready), 0);
    applyStimulus(1, 2'b00, 5'd5, 0, 0);
    checkOutput("full_ignored_count", 32'(count), 4);
    for (int k = 0; k < 4; k++) begin
      checkOutput("drainA_outa", 32'(outa), 32'(drainA[k]));
      checkOutput("drainA_out_op", 32'(out_op), 32'(k));
      applyStimulus(0, 2'b00, 5'd0, 1, 0);
    end
    checkOutput("drainA_out_valid", 32'(out_valid), 0);
    checkOutput("drainA_count", 32'(count), 0);

    // Streaming push and pop every cycle
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 2'(i % 4), 5'(i), 1, 0);
      checkOutput("stream_count", 32'(count), 1);
      checkOutput("stream_outa", 32'(outa), 32'(i));
    end
    applyStimulus(0, 2'b00, 5'd0, 1, 0);
    checkOutput("stream_end_count", 32'(count), 0);

    // Full with simultaneous push and pop: pop only, push lands next cycle
    for (int i = 10; i <= 13; i++) applyStimulus(1, 2'b01, 5'(i), 0, 0);
    checkOutput("fullB_count", 32'(count), 4);
    applyStimulus(1, 2'b01, 5'd20, 1, 0);
    checkOutput("fullB_poponly_count", 32'(count), 3);
    checkOutput("fullB_poponly_outa", 32'(outa), 11);
    applyStimulus(1, 2'b01, 5'd20, 0, 0);
    checkOutput("fullB_push_count", 32'(count), 4);
    for (int k = 0; k < 4; k++) begin
      checkOutput("drainB_outa", 32'(outa), 32'(drainB[k]));
      applyStimulus(0, 2'b00, 5'd0, 1, 0);
    end
    checkOutput("drainB_count", 32'(count), 0);

`ifdef RES_ACC_EN
    // Saturation after nine pops of 31, then clear beats a same-cycle pop
    applyStimulus(0, 2'b00, 5'd0, 0, 1);
    checkOutput("clr_acc", 32'(acc), 0);
    checkOutput("clr_acc_sat", 32'(acc_sat), 0);
    for (int i = 0; i < 9; i++) applyStimulus(1, 2'b00, 5'd31, 1, 0);
    checkOutput("acc8_acc", 32'(acc), 248);
    checkOutput("acc8_sat", 32'(acc_sat), 0);
    applyStimulus(0, 2'b00, 5'd0, 1, 0);
    checkOutput("acc9_acc", 32'(acc), 255);
    checkOutput("acc9_sat", 32'(acc_sat), 1);
    applyStimulus(1, 2'b00, 5'd31, 0, 0);
    checkOutput("sticky_sat", 32'(acc_sat), 1);
    applyStimulus(0, 2'b00, 5'd0, 1, 1);
    checkOutput("clrpop_acc", 32'(acc), 0);
    checkOutput("clrpop_sat", 32'(acc_sat), 0);
    checkOutput("clrpop_count", 32'(count), 0);
`endif

    // Asynchronous reset mid-operation discards entries at once
    for (int i = 21; i <= 23; i++) applyStimulus(1, 2'b10, 5'(i), 0, 0);
    checkOutput("prerst_count", 32'(count), 3);
    in_valid = 0;
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncrst_count", 32'(count), 0);
    checkOutput("asyncrst_out_valid", 32'(out_valid), 0);
    checkOutput("asyncrst_in_ready", 32'(in_ready), 1);
    checkOutput("asyncrst_outa", 32'(outa), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    applyStimulus(0, 2'b00, 5'd0, 1, 0);
    checkOutput("postrst_out_valid", 32'(out_valid), 0);
    applyStimulus(1, 2'b10, 5'd5, 0, 0);
    checkOutput("postrst_count", 32'(count), 1);
    checkOutput("postrst_outa", 32'(outa), 5);
    checkOutput("postrst_out_op", 32'(out_op), 2);
    applyStimulus(0, 2'b00, 5'd0, 1, 0);
    checkOutput("postrst_drain_count", 32'(count), 0);
    applyStimulus(0, 2'b00, 5'd0, 0, 0);
    applyStimulus(0, 2'b00, 5'd0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
